// File: rtl/c_one_hot_serializer_if.sv
// Handshake bundle for the one-hot serializer: multi-hot vector in, one-hot beats out.
// master drives the request side and consumes beats; slave is the serializer.
interface c_one_hot_serializer_if #(
    parameter int unsigned width = 8
);
    localparam int unsigned idx_width = (width > 1) ? $clog2(width) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [0:width-1]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:width-1]     out_data;
    logic [idx_width-1:0] out_index;
    logic                 out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/c_one_hot_serializer.sv
// Drains a multi-hot vector as one-hot beats, lowest index first, one beat per cycle.
// Beat outputs are decoded from the registered residual; the final beat can overlap the next load.
module c_one_hot_serializer #(
    parameter int unsigned width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    c_one_hot_serializer_if.slave   bus,
    output logic                    busy
);
    localparam int unsigned idx_width = (width > 1) ? $clog2(width) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state;
    logic [0:width-1]     residual;
    logic [0:width-1]     first_hot;
    logic [0:width-1]     rest;
    logic [idx_width-1:0] first_idx;
    logic                 draining;
    logic                 accept;
    logic                 xfer;

    // Lowest-index set bit of the residual; scanning downward lets the last hit win.
    always_comb begin
        first_hot = '0;
        first_idx = '0;
        for (int i = int'(width) - 1; i >= 0; i--) begin
            if (residual[i]) begin
                first_hot    = '0;
                first_hot[i] = 1'b1;
                first_idx    = idx_width'(i);
            end
        end
        rest = residual & ~first_hot;
    end

    always_comb begin
        draining      = (state == DRAIN);
        bus.out_valid = draining;
        bus.out_data  = draining ? first_hot : '0;
        bus.out_index = draining ? first_idx : '0;
        bus.out_last  = draining && (rest == '0);
        bus.in_ready  = !draining || (bus.out_ready && bus.out_last);
        accept        = bus.in_valid && bus.in_ready;
        xfer          = draining && bus.out_ready;
    end

    assign busy = (state == DRAIN);

    // A nonzero load takes priority; it can only coincide with the final beat transferring.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            residual <= '0;
        end else if (accept && (bus.in_data != '0)) begin
            state    <= DRAIN;
            residual <= bus.in_data;
        end else if (xfer) begin
            residual <= rest;
            if (rest == '0) begin
                state <= IDLE;
            end
        end
    end
endmodule
